systolic_feeder: RTL

- Upstream scheduler for the 4x4 output-stationary systolic array of 32-bit MAC PEs.
- Accepts an N x N A tile and an N x N B tile as N streamed beats, one k-index per beat, and buffers them.
- Clears the array accumulators, then drives the west and north array edges with the diagonally skewed operand wavefront.
- Signals completion once every PE accumulator holds its final C[i][j] = sum over k of A[i][k]*B[k][j].

---
 rtl/systolic_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand scheduler for an N x N output-stationary systolic array: buffers one A/B tile,
// clears the array, then drives the diagonally skewed west/north wavefront.
module systolic_feeder #(
    parameter int DW = 32,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic            array_clr,
    output logic            feed_valid,
    output logic [N*DW-1:0] west_data,
    output logic [N*DW-1:0] north_data,
    output logic            busy,
    output logic            done
);

    localparam int LW       = (N > 1) ? $clog2(N) : 1;
    localparam int FEED_LEN = 3 * N - 2;
    localparam int MW       = $clog2(FEED_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_FEED  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [LW-1:0]     ld_cnt_r;
    logic [MW-1:0]     feed_cnt_r;
    logic [DW-1:0]     a_buf_r [N][N];
    logic [DW-1:0]     b_buf_r [N][N];
    logic              in_ready_r;
    logic              array_clr_r;
    logic              feed_valid_r;
    logic              busy_r;
    logic              done_r;
    logic [N*DW-1:0]   west_r;
    logic [N*DW-1:0]   north_r;

    logic              accept_s;
    logic [MW-1:0]     wave_m_s;
    logic [N*DW-1:0]   west_nxt_s;
    logic [N*DW-1:0]   north_nxt_s;

    assign accept_s = in_valid & in_ready_r;

    // Edge values for the wavefront step that will be shown next cycle.
    always_comb begin
        wave_m_s    = (state_r == S_CLEAR) ? {MW{1'b0}} : (feed_cnt_r + {{(MW-1){1'b0}}, 1'b1});
        west_nxt_s  = {(N*DW){1'b0}};
        north_nxt_s = {(N*DW){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                // lane i carries the operand whose k index equals m - i; otherwise literal 0
                west_nxt_s[i*DW +: DW]  = west_nxt_s[i*DW +: DW] |
                    ((wave_m_s == MW'(i + k)) ? a_buf_r[i][k] : {DW{1'b0}});
                north_nxt_s[i*DW +: DW] = north_nxt_s[i*DW +: DW] |
                    ((wave_m_s == MW'(i + k)) ? b_buf_r[k][i] : {DW{1'b0}});
            end
        end
    end

    // Tile buffers: beat k fills column k of A and row k of B.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_buf_r[i][k] <= {DW{1'b0}};
                    b_buf_r[k][i] <= {DW{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int i = 0; i < N; i++) begin
                a_buf_r[i][ld_cnt_r] <= a_col[i*DW +: DW];
                b_buf_r[ld_cnt_r][i] <= b_row[i*DW +: DW];
            end
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            ld_cnt_r     <= {LW{1'b0}};
            feed_cnt_r   <= {MW{1'b0}};
            in_ready_r   <= 1'b0;
            array_clr_r  <= 1'b0;
            feed_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            west_r       <= {(N*DW){1'b0}};
            north_r      <= {(N*DW){1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_LOAD: begin
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    if (accept_s) begin
                        if (ld_cnt_r == LW'(N - 1)) begin
                            ld_cnt_r    <= {LW{1'b0}};
                            in_ready_r  <= 1'b0;
                            array_clr_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= S_CLEAR;
                        end else begin
                            ld_cnt_r <= ld_cnt_r + {{(LW-1){1'b0}}, 1'b1};
                            state_r  <= S_LOAD;
                        end
                    end
                end
                S_CLEAR: begin
                    array_clr_r  <= 1'b0;
                    feed_valid_r <= 1'b1;
                    feed_cnt_r   <= {MW{1'b0}};
                    west_r       <= west_nxt_s;
                    north_r      <= north_nxt_s;
                    state_r      <= S_FEED;
                end
                S_FEED: begin
                    if (feed_cnt_r == MW'(FEED_LEN - 1)) begin
                        feed_valid_r <= 1'b0;
                        west_r       <= {(N*DW){1'b0}};
                        north_r      <= {(N*DW){1'b0}};
                        done_r       <= 1'b1;
                        state_r      <= S_DONE;
                    end else begin
                        feed_cnt_r <= feed_cnt_r + {{(MW-1){1'b0}}, 1'b1};
                        west_r     <= west_nxt_s;
                        north_r    <= north_nxt_s;
                    end
                end
                S_DONE: begin
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
                default: begin
                    state_r      <= S_IDLE;
                    ld_cnt_r     <= {LW{1'b0}};
                    feed_cnt_r   <= {MW{1'b0}};
                    in_ready_r   <= 1'b0;
                    array_clr_r  <= 1'b0;
                    feed_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    west_r       <= {(N*DW){1'b0}};
                    north_r      <= {(N*DW){1'b0}};
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign array_clr  = array_clr_r;
    assign feed_valid = feed_valid_r;
    assign west_data  = west_r;
    assign north_data = north_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
